uart_rx: RTL and testbench

- 8N1 UART receiver. Deserialises the asynchronous RX line into bytes and presents each byte on a valid/ready handshake.
- Counterpart of the on-chip UART transmitter. Same bit-rate derivation, LSB-first, 1 start bit, 8 data bits, 1 stop bit, no parity.
- Sits between the board RX pin and host-command/debug logic in the `clk` domain.

---
 rtl/uart_rx.sv | 152 +++++++++++++++
 tb/tb_uart_rx.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop RX sync, mid-bit sampling, byte on valid/ready; valid rises 1 clk after the stop sample.
// Backpressure: a good byte arriving while valid && !ready is dropped and sets the sticky overrun flag.
module uart_rx #(
  parameter int CLK_FREQ  = 133000000,
  parameter int UART_FREQ = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       ready,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int BIT_DIV  = CLK_FREQ / UART_FREQ;
  localparam int HALF_DIV = BIT_DIV / 2;
  localparam logic [10:0] BIT_LOAD  = 11'(BIT_DIV - 1);
  localparam logic [10:0] HALF_LOAD = 11'(HALF_DIV - 1);

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t      state_q, state_d;
  logic        rx_meta_q, rx_meta_d;
  logic        rx_s_q, rx_s_d;
  logic [10:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;
  logic        cnt_zero;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= WAIT_IDLE;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_meta_q   <= rx_meta_d;
      rx_s_q      <= rx_s_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign cnt_zero = (cnt_q == 11'd0);

  always_comb begin
    state_d     = state_q;
    rx_meta_d   = RX;
    rx_s_d      = rx_meta_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = overrun_q;

    // Consume; a byte accepted in the same cycle overrides this below.
    if (valid_q && ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      WAIT_IDLE: begin
        if (rx_s_q) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          cnt_d   = HALF_LOAD;
        end
      end
      START: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 11'd1;
        end else if (!rx_s_q) begin
          state_d   = DATA;
          cnt_d     = BIT_LOAD;
          bit_idx_d = 3'd0;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 11'd1;
        end else begin
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          cnt_d     = BIT_LOAD;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 11'd1;
        end else if (rx_s_q) begin
          state_d = IDLE;
          if (!valid_q || ready) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end else begin
          // Bad stop: wait for the line to return high before hunting again.
          frame_err_d = 1'b1;
          state_d     = WAIT_IDLE;
        end
      end
      default: begin
        state_d = WAIT_IDLE;
      end
    endcase
  end

  assign data_out  = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q == START) || (state_q == DATA) || (state_q == STOP);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit (CLK_FREQ=16, UART_FREQ=1).
module tb_uart_rx;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       RX;
  logic       ready_main;
  logic       ready_pulse = 1'b0;
  logic       ready;
  logic [7:0] data_out;
  logic       valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulse_at = -1;
  int fe_cnt = 0;
  int busy_seen = 0;
  int rise_cyc = -1;
  int start_cyc = 0;
  logic valid_prev = 1'b0;

  uart_rx #(.CLK_FREQ(16), .UART_FREQ(1)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .ready(ready),
    .data_out(data_out), .valid(valid), .frame_err(frame_err),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;
  assign ready = ready_main | ready_pulse;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    ready_pulse = (cyc == pulse_at);
    if (frame_err === 1'b1) fe_cnt = fe_cnt + 1;
    if (busy === 1'b1) busy_seen = 1;
    if (valid === 1'b1 && valid_prev !== 1'b1) rise_cyc = cyc;
    valid_prev = valid;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_val, input int stop_bits);
    RX = 1'b0;
    wait_clk(16);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      wait_clk(16);
    end
    RX = stop_val;
    wait_clk(16 * stop_bits);
    RX = 1'b1;
  endtask

  task automatic consume();
    ready_main = 1'b1;
    wait_clk(1);
    ready_main = 1'b0;
  endtask

  initial begin
    RX = 1'b1;
    ready_main = 1'b1;
    rst_n = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(5);
    chk("rst_valid", valid, 0);
    chk("rst_data", data_out, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_busy", busy, 0);

    // 0xA5 with latency: rx_s sees the edge 2 clk after the drive, valid 153 clk later.
    ready_main = 1'b0;
    fe_cnt = 0;
    rise_cyc = -1;
    start_cyc = cyc;
    send_frame(8'hA5, 1'b1, 1);
    chk("a5_valid", valid, 1);
    chk("a5_data", data_out, 8'hA5);
    chk("a5_no_ferr", fe_cnt, 0);
    chk("a5_latency", rise_cyc - start_cyc, 155);
    chk("a5_busy_done", busy, 0);
    consume();
    chk("a5_consumed", valid, 0);
    chk("a5_data_held", data_out, 8'hA5);

    // Overrun: 0x81 arrives while 0x3C is still unconsumed.
    send_frame(8'h3C, 1'b1, 1);
    chk("3c_data", data_out, 8'h3C);
    chk("3c_no_ovr", overrun, 0);
    send_frame(8'h81, 1'b1, 1);
    chk("ovr_data_kept", data_out, 8'h3C);
    chk("ovr_flag", overrun, 1);
    chk("ovr_valid", valid, 1);
    consume();
    chk("ovr_consumed", valid, 0);

    // Framing error, then recovery with 0x0F.
    fe_cnt = 0;
    send_frame(8'h55, 1'b0, 2);
    wait_clk(4);
    chk("ferr_pulse_cnt", fe_cnt, 1);
    chk("ferr_no_valid", valid, 0);
    send_frame(8'h0F, 1'b1, 1);
    chk("0f_valid", valid, 1);
    chk("0f_data", data_out, 8'h0F);
    chk("0f_ferr_cnt", fe_cnt, 1);
    chk("0f_ovr_sticky", overrun, 1);
    consume();

    // Start glitch shorter than half a bit.
    busy_seen = 0;
    fe_cnt = 0;
    RX = 1'b0;
    wait_clk(4);
    RX = 1'b1;
    wait_clk(30);
    chk("glitch_busy_seen", busy_seen, 1);
    chk("glitch_busy_end", busy, 0);
    chk("glitch_no_valid", valid, 0);
    chk("glitch_no_ferr", fe_cnt, 0);

    // Reset in the middle of a frame.
    RX = 1'b0;
    wait_clk(16);
    RX = 1'b1;
    wait_clk(16);
    RX = 1'b0;
    wait_clk(8);
    chk("midrst_busy_before", busy, 1);
    rst_n = 1'b0;
    wait_clk(2);
    rst_n = 1'b1;
    RX = 1'b1;
    wait_clk(1);
    chk("midrst_busy", busy, 0);
    chk("midrst_overrun", overrun, 0);
    chk("midrst_data", data_out, 0);
    wait_clk(200);
    chk("midrst_no_valid", valid, 0);
    chk("midrst_no_ferr", fe_cnt, 0);

    // Back-to-back frames; ready pulses in the cycle the second stop is sampled.
    send_frame(8'h12, 1'b1, 1);
    chk("b2b_first_valid", valid, 1);
    chk("b2b_first_data", data_out, 8'h12);
    pulse_at = cyc + 154;
    send_frame(8'h34, 1'b1, 1);
    chk("b2b_second_valid", valid, 1);
    chk("b2b_second_data", data_out, 8'h34);
    chk("b2b_no_overrun", overrun, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
